// File: rtl/array_unpack_reader.sv
// Unpacks one concatenated WIDTH*DEPTH word into a register array and streams
// the entries out over valid/ready, entry 0 (the MSBs) first.
module array_unpack_reader #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  logic [0:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // flush has no effect here, so an accept still proceeds
          if (in_valid) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
              mem[k] <= in_data[WIDTH*(DEPTH-k)-1 -: WIDTH];
            end
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          // flush wins over a same-cycle handshake: that entry is not transferred
          if (flush) begin
            idx   <= '0;
            state <= IDLE;
          end else if (out_ready) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_idx   = idx;
    out_last  = 1'b0;
    if (state == STREAM) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = mem[idx];
      out_last  = (idx == LAST);
    end
  end

endmodule
